// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parameterised synchronous FIFO.
//   fifo_mode_e : read-side behaviour (registered read or first-word-fall-through)
//   next_ptr    : pointer increment with an explicit wrap at depth-1, valid for any depth
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Wraps from depth-1 back to 0; depth need not be a power of two.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH register array, one synchronous write port, one asynchronous read port.
// Contents are not reset.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data at rd_addr
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with any DEPTH >= 2, selectable standard / FWFT read mode,
// almost-full/almost-empty thresholds, occupancy output, synchronous flush and
// sticky overflow/underflow flags.
//   clk, rst_n    : clock, asynchronous active-low reset
//   flush         : synchronous clear of contents and sticky flags
//   wr_en/wr_data : write request and data
//   rd_en         : read (STD) or pop/acknowledge (FWFT)
//   rd_data       : read data; rd_valid qualifies it
//   empty/full/almost_empty/almost_full/level : status from the registered level
//   overflow/underflow : sticky error flags
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter fifo_mode_e  MODE      = FIFO_STD,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    // Elaboration-time parameter sanity
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "param_sync_fifo: DEPTH must be >= 2");
    end
    if (AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "param_sync_fifo: AF_THRESH must be <= DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $fatal(1, "param_sync_fifo: AE_THRESH must be < DEPTH");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] mem_rd_data;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             rd_acc_c;
    logic             wr_acc_c;

    // Status flags, all from the registered level
    assign empty        = (level_q == '0);
    assign full         = (level_q == LW'(DEPTH));
    assign almost_empty = (level_q <= LW'(AE_THRESH));
    assign almost_full  = (level_q >= LW'(AF_THRESH));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write into a full FIFO is accepted when a pop frees a slot in the same cycle
    assign rd_acc_c = rd_en && !empty;
    assign wr_acc_c = wr_en && (!full || rd_acc_c);

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc_c && !flush),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    // Pointers, level, sticky flags and the standard-mode read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= PW'(next_ptr(32'(wr_ptr), DEPTH));
            end
            if (rd_acc_c) begin
                rd_ptr <= PW'(next_ptr(32'(rd_ptr), DEPTH));
            end
            case ({wr_acc_c, rd_acc_c})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (wr_en && full && !rd_acc_c) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
            rd_valid_q <= (MODE == FIFO_STD) && rd_acc_c;
            if ((MODE == FIFO_STD) && rd_acc_c) begin
                rd_data_q <= mem_rd_data;
            end
        end
    end

    // FWFT exposes the head word directly; zero while empty keeps the output defined
    assign rd_data  = (MODE == FIFO_FWFT) ? (empty ? '0 : mem_rd_data) : rd_data_q;
    assign rd_valid = (MODE == FIFO_FWFT) ? !empty : rd_valid_q;

endmodule
